// File: rtl/fip_32_det_sched.sv
// Round-robin front end for one shared pipelined 3x3 determinant unit.
// Grants one requester per cycle, tags the issue with its ID and routes the result back.
module fip_32_det_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ*288-1:0]     i_req_mat,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic                    i_hold,
  output logic                    o_det_en,
  output logic [287:0]            o_det_mat,
  input  logic signed [31:0]      i_det_result,
  input  logic                    i_det_valid,
  output logic [NREQ-1:0]         o_rsp_valid,
  output logic [IDW-1:0]          o_rsp_id,
  output logic signed [31:0]      o_rsp_det,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int MAT_W = 288;
  localparam logic [NREQ-1:0] ONE_HOT = {{(NREQ-1){1'b0}}, 1'b1};

  logic [IDW-1:0] ptr_p0;
  logic           found;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] ptr_nxt;
  logic           grant;

  logic [LAT-1:0] vld_p;
  logic [IDW-1:0] tag_id_p [LAT];

  // Scan from the pointer downward in offset so the nearest requester wins.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] req,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Stage p0: arbitration and issue (combinational, gated by reset)
  always_comb begin
    {found, pick_id} = rr_pick(i_req_valid, ptr_p0);
    grant       = i_rstn & ~i_hold & found;
    ptr_nxt     = (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + IDW'(1);
    o_req_ready = '0;
    o_det_en    = 1'b0;
    o_det_mat   = '0;
    if (grant) begin
      o_req_ready = ONE_HOT << pick_id;
      o_det_en    = 1'b1;
      o_det_mat   = i_req_mat[int'(pick_id)*MAT_W +: MAT_W];
    end
  end

  // Stage p1..pLAT: tag pipe mirrors the det unit; response captured off the last tag
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr_p0      <= '0;
      vld_p       <= '0;
      for (int s = 0; s < LAT; s++) tag_id_p[s] <= '0;
      o_rsp_valid <= '0;
      o_rsp_id    <= '0;
      o_rsp_det   <= '0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      if (grant) ptr_p0 <= ptr_nxt;
      vld_p[0]    <= o_det_en;
      tag_id_p[0] <= pick_id;
      for (int s = 1; s < LAT; s++) begin
        vld_p[s]    <= vld_p[s-1];
        tag_id_p[s] <= tag_id_p[s-1];
      end
      if (vld_p[LAT-1]) begin
        o_rsp_valid <= ONE_HOT << tag_id_p[LAT-1];
        o_rsp_id    <= tag_id_p[LAT-1];
        o_rsp_det   <= i_det_result;
      end else begin
        o_rsp_valid <= '0;
      end
      o_busy <= o_det_en | (|vld_p);
      if (i_det_valid != vld_p[LAT-1]) o_err <= 1'b1;
    end
  end

endmodule
